perf_counter_initiator: RTL and testbench
=========================================

# perf_counter_initiator

Avalon-MM master that drives the 8-section performance-counter slave from hardware instead of Nios software. It converts start/stop pulses from the image-processing cores into go/stop writes. On request it reads back the time and event counters of every section and emits them as a ready/valid record stream. It sits beside the accelerator cores and shares the counter slave's control port through the system interconnect.

## Interface
- NUM_SEC, 8, number of sections handled (1..8); section s uses word addresses 4s (stop / time lo), 4s+1 (go / time hi), 4s+2 (events)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sec_start  in  NUM_SEC  one-cycle start pulse per section
- sec_stop  in  NUM_SEC  one-cycle stop pulse per section
- clear_req  in  1  pulse: global counter clear
- dump_req  in  1  pulse: read back all sections
- avm_address  out  5  word address
- avm_write  out  1  write strobe, one cycle per transfer
- avm_read  out  1  read strobe
- avm_begintransfer  out  1  asserted with every avm_write/avm_read cycle
- avm_writedata  out  32  write data
- avm_readdata  in  32  slave data; fixed read latency 1
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accept
- res_sec  out  3  section index of record
- res_time  out  64  time counter {hi,lo}
- res_events  out  32  event counter
- busy  out  1  FSM not in IDLE or any request pending
- dropped  out  1  sticky: a pulse hit an already-pending request; cleared by clear_req

## Operation
- Pending registers: start_pend, stop_pend (NUM_SEC each), clr_pend, dump_pend. Each is set by its pulse and cleared when granted. A pulse on an already-set bit sets dropped.
- Grant priority in IDLE: clr_pend, then stop_pend (lowest index first), then start_pend (lowest index first), then dump_pend.
- Clear: write addr 0, data 0x1. Granting clr also clears every start_pend/stop_pend bit, because the slave reset stops all counters.
- Stop s: write addr 4s, data 0. Start s: write addr 4s+1, data 0.
- When start and stop of the same section arrive together, the stop is issued first, then the start.
- Section 0 gates all others in the slave. The initiator does not enforce this; software/cores must start section 0.
- Dump is atomic: sections 0..NUM_SEC-1 are read in order and no writes are issued until the dump completes. Pulses arriving during the dump still set pending bits.
- FSM states: IDLE, WR, RD_LO, RD_HI, RD_EV, RD_CAP, OUT.
- WR lasts one cycle, then returns to IDLE.
- Read sequence: RD_LO drives 4s; RD_HI drives 4s+1 and captures lo; RD_EV drives 4s+2 and captures hi; RD_CAP captures events; OUT holds res_valid until res_ready. Then s+1 goes to RD_LO, or the last section returns to IDLE.
- avm_writedata is 0 when not writing.

## Timing
- Reset values: all avm_* outputs 0, res_valid 0, res_* 0, busy 0, dropped 0, all pending bits 0, FSM in IDLE, section index 0.
- All bus outputs are registered.
- A pulse in cycle N causes avm_write in cycle N+2 if IDLE with no higher-priority request.
- Consecutive grants give back-to-back writes: IDLE→WR→IDLE costs 2 cycles per write.
- Read data is sampled exactly one cycle after the read address cycle. There is no waitrequest.
- Per-section dump latency is 4 cycles from RD_LO to res_valid. res_valid stays high with all res_* stable until res_ready is sampled high.
- clear_req arriving during a dump is serviced after the dump.
- reset_n assertion mid-transfer drops all bus strobes immediately (async). The record in progress is lost.

## Structure
- Shared package pc_pkg: address offset constants (STOP_OFS=0, GO_OFS=1, EV_OFS=2, SEC_STRIDE=4), FSM state enum, result record struct.
- Natural sub-module: pc_req_arb, which holds the pending registers, dropped flag and fixed-priority grant encoder. The top module holds the FSM and datapath.

## Test plan
- sec_start[0] pulse at cycle 10 → avm_write=1, addr=1 at cycle 12, one cycle only; busy falls at cycle 13.
- sec_start[3] and sec_stop[3] in the same cycle → write addr 12, then write addr 13 on consecutive write slots.
- Second sec_start[2] while the first is still pending (held off by a dump) → dropped=1, only one addr-9 write; clear_req → dropped=0 and write addr 0 with data 0x1.
- Slave model returns lo=0x11, hi=0x22, ev=0x33 for section 5; dump_req → record res_sec=5, res_time=0x00000022_00000011, res_events=0x33; 8 records in order 0..7.
- res_ready held low 20 cycles on record 0 → res_* stable, no bus activity; sec_stop[1] during the dump → write addr 4 only after the last record.
- reset_n low mid-dump (state RD_EV) → all outputs 0 asynchronously; after release busy=0 and no stale record appears.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the performance-counter initiator: slave address map,
// FSM states, grant kinds and the result record.
package pc_pkg;

    localparam int unsigned STOP_OFS   = 0;
    localparam int unsigned GO_OFS     = 1;
    localparam int unsigned EV_OFS     = 2;
    localparam int unsigned SEC_STRIDE = 4;

    localparam logic [31:0] CLR_DATA = 32'h0000_0001;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdLo,
        StRdHi,
        StRdEv,
        StRdCap,
        StOut
    } pc_state_e;

    typedef enum logic [1:0] {
        GntClr,
        GntStop,
        GntStart,
        GntDump
    } pc_gnt_e;

    typedef struct packed {
        logic [2:0]  sec;
        logic [63:0] tm;
        logic [31:0] events;
    } pc_rec_t;

    function automatic logic [4:0] sec_addr(input logic [2:0] sec, input int unsigned ofs);
        return 5'(32'(sec) * SEC_STRIDE + ofs);
    endfunction

endpackage

// File: rtl/pc_req_arb.sv
// Pending-request registers, sticky drop flag and fixed-priority grant encoder
// (clear, then stops, then starts, then dump; lowest section index first).
module pc_req_arb
    import pc_pkg::*;
#(
    parameter int unsigned NUM_SEC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SEC-1:0] sec_start,
    input  logic [NUM_SEC-1:0] sec_stop,
    input  logic               clear_req,
    input  logic               dump_req,
    input  logic               grant_take,
    output logic               gnt_valid,
    output logic [1:0]         gnt_kind,
    output logic [2:0]         gnt_sec,
    output logic               pend_any,
    output logic               dropped
);

    logic [NUM_SEC-1:0] start_q, start_d, stop_q, stop_d, sec_mask;
    logic               clr_q, clr_d, dump_q, dump_d, dropped_q, dropped_d;
    logic               start_hit, stop_hit, take, drop_now;
    logic [2:0]         start_idx, stop_idx;
    pc_gnt_e            kind;

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        start_hit = 1'b0;
        start_idx = '0;
        stop_hit  = 1'b0;
        stop_idx  = '0;
        for (int i = int'(NUM_SEC) - 1; i >= 0; i--) begin
            if (start_q[i]) begin
                start_hit = 1'b1;
                start_idx = 3'(i);
            end
            if (stop_q[i]) begin
                stop_hit = 1'b1;
                stop_idx = 3'(i);
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b1;
        kind      = GntDump;
        gnt_sec   = '0;
        if (clr_q) begin
            kind = GntClr;
        end else if (stop_hit) begin
            kind    = GntStop;
            gnt_sec = stop_idx;
        end else if (start_hit) begin
            kind    = GntStart;
            gnt_sec = start_idx;
        end else if (!dump_q) begin
            gnt_valid = 1'b0;
        end
    end

    always_comb begin
        start_d  = start_q;
        stop_d   = stop_q;
        clr_d    = clr_q;
        dump_d   = dump_q;
        sec_mask = NUM_SEC'(1) << gnt_sec;
        take     = grant_take & gnt_valid;
        if (take) begin
            unique case (kind)
                // The slave reset stops every counter, so outstanding start/stop
                // requests become meaningless.
                GntClr: begin
                    clr_d   = 1'b0;
                    start_d = '0;
                    stop_d  = '0;
                end
                GntStop:  stop_d  = stop_q & ~sec_mask;
                GntStart: start_d = start_q & ~sec_mask;
                GntDump:  dump_d  = 1'b0;
            endcase
        end
        start_d = start_d | sec_start;
        stop_d  = stop_d | sec_stop;
        clr_d   = clr_d | clear_req;
        dump_d  = dump_d | dump_req;

        drop_now  = (|(sec_start & start_q)) | (|(sec_stop & stop_q)) |
                    (clear_req & clr_q) | (dump_req & dump_q);
        dropped_d = (dropped_q & ~clear_req) | drop_now;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q   <= '0;
            stop_q    <= '0;
            clr_q     <= 1'b0;
            dump_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            start_q   <= start_d;
            stop_q    <= stop_d;
            clr_q     <= clr_d;
            dump_q    <= dump_d;
            dropped_q <= dropped_d;
        end
    end

    assign gnt_kind = kind;
    assign pend_any = clr_q | dump_q | (|start_q) | (|stop_q);
    assign dropped  = dropped_q;

endmodule

// File: rtl/perf_counter_initiator.sv
// Avalon-MM master that turns start/stop/clear pulses into counter-slave writes
// and reads every section back into a ready/valid record stream on request.
module perf_counter_initiator
    import pc_pkg::*;
#(
    parameter int unsigned NUM_SEC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SEC-1:0] sec_start,
    input  logic [NUM_SEC-1:0] sec_stop,
    input  logic               clear_req,
    input  logic               dump_req,
    output logic [4:0]         avm_address,
    output logic               avm_write,
    output logic               avm_read,
    output logic               avm_begintransfer,
    output logic [31:0]        avm_writedata,
    input  logic [31:0]        avm_readdata,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2:0]         res_sec,
    output logic [63:0]        res_time,
    output logic [31:0]        res_events,
    output logic               busy,
    output logic               dropped
);

    localparam logic [2:0] LAST_SEC = 3'(NUM_SEC - 1);

    pc_state_e   state_q, state_d;
    logic [2:0]  sec_q, sec_d;
    pc_rec_t     rec_q, rec_d;
    logic        res_valid_q, res_valid_d;
    logic        wr_q, wr_d, rd_q, rd_d, bt_q;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        gnt_valid, grant_take, pend_any;
    logic [1:0]  gnt_kind;
    logic [2:0]  gnt_sec;

    pc_req_arb #(
        .NUM_SEC (NUM_SEC)
    ) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .sec_start  (sec_start),
        .sec_stop   (sec_stop),
        .clear_req  (clear_req),
        .dump_req   (dump_req),
        .grant_take (grant_take),
        .gnt_valid  (gnt_valid),
        .gnt_kind   (gnt_kind),
        .gnt_sec    (gnt_sec),
        .pend_any   (pend_any),
        .dropped    (dropped)
    );

    // Bus strobes are computed for the state being entered so they can be registered.
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        rec_d       = rec_q;
        res_valid_d = res_valid_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        grant_take  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    grant_take = 1'b1;
                    unique case (pc_gnt_e'(gnt_kind))
                        GntClr: begin
                            state_d = StWr;
                            wr_d    = 1'b1;
                            wdata_d = CLR_DATA;
                        end
                        GntStop: begin
                            state_d = StWr;
                            wr_d    = 1'b1;
                            addr_d  = sec_addr(gnt_sec, STOP_OFS);
                        end
                        GntStart: begin
                            state_d = StWr;
                            wr_d    = 1'b1;
                            addr_d  = sec_addr(gnt_sec, GO_OFS);
                        end
                        GntDump: begin
                            state_d = StRdLo;
                            sec_d   = '0;
                            rd_d    = 1'b1;
                            addr_d  = sec_addr(3'd0, STOP_OFS);
                        end
                    endcase
                end
            end
            StWr: state_d = StIdle;
            StRdLo: begin
                state_d = StRdHi;
                rd_d    = 1'b1;
                addr_d  = sec_addr(sec_q, GO_OFS);
            end
            StRdHi: begin
                rec_d.tm[31:0] = avm_readdata;
                state_d        = StRdEv;
                rd_d           = 1'b1;
                addr_d         = sec_addr(sec_q, EV_OFS);
            end
            StRdEv: begin
                rec_d.tm[63:32] = avm_readdata;
                state_d         = StRdCap;
            end
            StRdCap: begin
                rec_d.events = avm_readdata;
                rec_d.sec    = sec_q;
                res_valid_d  = 1'b1;
                state_d      = StOut;
            end
            StOut: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (sec_q == LAST_SEC) begin
                        state_d = StIdle;
                    end else begin
                        sec_d   = sec_q + 3'd1;
                        state_d = StRdLo;
                        rd_d    = 1'b1;
                        addr_d  = sec_addr(sec_q + 3'd1, STOP_OFS);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sec_q       <= '0;
            rec_q       <= '0;
            res_valid_q <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            bt_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            rec_q       <= rec_d;
            res_valid_q <= res_valid_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            bt_q        <= wr_d | rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign avm_address       = addr_q;
    assign avm_write         = wr_q;
    assign avm_read          = rd_q;
    assign avm_begintransfer = bt_q;
    assign avm_writedata     = wdata_q;
    assign res_valid         = res_valid_q;
    assign res_sec           = rec_q.sec;
    assign res_time          = rec_q.tm;
    assign res_events        = rec_q.events;
    assign busy              = (state_q != StIdle) | pend_any;

endmodule

// File: tb/tb_perf_counter_initiator.sv
// Directed bench for perf_counter_initiator with a latency-1 counter-slave model.
module tb_perf_counter_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  sec_start, sec_stop;
    logic        clear_req, dump_req;
    logic [4:0]  avm_address;
    logic        avm_write, avm_read, avm_begintransfer;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        res_valid, res_ready;
    logic [2:0]  res_sec;
    logic [63:0] res_time;
    logic [31:0] res_events;
    logic        busy, dropped;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int proto_bad = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t wr_log[$];

    logic [31:0] mem [0:31];

    perf_counter_initiator #(
        .NUM_SEC (8)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sec_start         (sec_start),
        .sec_stop          (sec_stop),
        .clear_req         (clear_req),
        .dump_req          (dump_req),
        .avm_address       (avm_address),
        .avm_write         (avm_write),
        .avm_read          (avm_read),
        .avm_begintransfer (avm_begintransfer),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_sec           (res_sec),
        .res_time          (res_time),
        .res_events        (res_events),
        .busy              (busy),
        .dropped           (dropped)
    );

    always #5 clk = ~clk;

    // Slave model plus write logger and strobe consistency monitor.
    always @(posedge clk) begin
        if (avm_read) avm_readdata <= mem[avm_address];
        if (avm_write) wr_log.push_back('{cyc, avm_address, avm_writedata});
        if (avm_begintransfer !== (avm_write | avm_read)) proto_bad++;
        if (!avm_write && avm_writedata !== 32'h0) proto_bad++;
        cyc <= cyc + 1;
    end

    // Section 5 returns lo=0x11, hi=0x22, ev=0x33; others are distinct variants.
    function automatic logic [31:0] slave_word(int s, logic [31:0] base);
        return base ^ (32'(s ^ 5) << 20);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({avm_write, avm_read, avm_begintransfer} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 000", {avm_write, avm_read, avm_begintransfer});
        end
        n_tests++;
        if (avm_address !== 5'd0 || avm_writedata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus: addr %0d data %h want 0 0", avm_address, avm_writedata);
        end
        n_tests++;
        if (res_valid !== 1'b0 || res_sec !== 3'd0 || res_time !== 64'd0 || res_events !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_res: valid %b sec %0d time %h ev %h want all 0",
                     res_valid, res_sec, res_time, res_events);
        end
        n_tests++;
        if (busy !== 1'b0 || dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy %b dropped %b want 0 0", busy, dropped);
        end
    endtask

    task automatic test_start0();
        while (cyc < 10) tick();
        sec_start = 8'h01;
        tick();
        sec_start = '0;
        n_tests++;
        if (avm_write !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start0_c11: write %b busy %b want 0 1", avm_write, busy);
        end
        tick();
        n_tests++;
        if (cyc !== 12 || avm_write !== 1'b1 || avm_address !== 5'd1 || avm_writedata !== 32'd0) begin
            n_fail++;
            $display("FAIL start0_c12: cyc %0d write %b addr %0d data %h want 12 1 1 0",
                     cyc, avm_write, avm_address, avm_writedata);
        end
        tick();
        n_tests++;
        if (avm_write !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start0_c13: write %b busy %b want 0 0", avm_write, busy);
        end
    endtask

    task automatic test_same_cycle();
        tick();
        sec_start = 8'h08;
        sec_stop  = 8'h08;
        tick();
        sec_start = '0;
        sec_stop  = '0;
        tick();
        n_tests++;
        if (avm_write !== 1'b1 || avm_address !== 5'd12) begin
            n_fail++;
            $display("FAIL same_stop_first: write %b addr %0d want 1 12", avm_write, avm_address);
        end
        tick();
        n_tests++;
        if (avm_write !== 1'b0) begin
            n_fail++;
            $display("FAIL same_gap: write %b want 0", avm_write);
        end
        tick();
        n_tests++;
        if (avm_write !== 1'b1 || avm_address !== 5'd13) begin
            n_fail++;
            $display("FAIL same_start_next: write %b addr %0d want 1 13", avm_write, avm_address);
        end
        tick();
        tick();
    endtask

    task automatic test_dump();
        int d;
        int k;
        res_ready = 1'b1;
        wr_log.delete();
        tick();
        d = cyc;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        k = 0;
        while (!res_valid && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (cyc !== d + 6) begin
            n_fail++;
            $display("FAIL dump_latency: first valid at cycle %0d want %0d", cyc, d + 6);
        end
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (!res_valid && k < 20) begin
                tick();
                k++;
            end
            n_tests++;
            if (res_valid !== 1'b1 || res_sec !== 3'(i) ||
                res_time !== {slave_word(i, 32'h22), slave_word(i, 32'h11)} ||
                res_events !== slave_word(i, 32'h33)) begin
                n_fail++;
                $display("FAIL dump_rec%0d: valid %b sec %0d time %h ev %h", i, res_valid,
                         res_sec, res_time, res_events);
            end
            if (i == 5) begin
                n_tests++;
                if (res_time !== 64'h0000_0022_0000_0011 || res_events !== 32'h33) begin
                    n_fail++;
                    $display("FAIL dump_sec5: time %h ev %h want 0000002200000011 00000033",
                             res_time, res_events);
                end
            end
            tick();
        end
        tick();
        tick();
        n_tests++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || wr_log.size() != 0) begin
            n_fail++;
            $display("FAIL dump_end: busy %b valid %b writes %0d want 0 0 0", busy, res_valid,
                     wr_log.size());
        end
    endtask

    task automatic test_backpressure();
        int k;
        int bad;
        int last;
        logic [98:0] snap;
        res_ready = 1'b0;
        wr_log.delete();
        tick();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        k = 0;
        while (!res_valid && k < 20) begin
            tick();
            k++;
        end
        snap = {res_sec, res_time, res_events};
        bad = 0;
        sec_stop = 8'h02;
        for (int j = 0; j < 20; j++) begin
            tick();
            sec_stop = '0;
            if ({res_sec, res_time, res_events} !== snap || res_valid !== 1'b1 ||
                avm_read !== 1'b0 || avm_write !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable or busy-bus cycles want 0", bad);
        end
        res_ready = 1'b1;
        last = 0;
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (!res_valid && k < 20) begin
                tick();
                k++;
            end
            n_tests++;
            if (res_valid !== 1'b1 || res_sec !== 3'(i)) begin
                n_fail++;
                $display("FAIL bp_order%0d: valid %b sec %0d", i, res_valid, res_sec);
            end
            last = cyc;
            tick();
        end
        n_tests++;
        if (wr_log.size() != 0) begin
            n_fail++;
            $display("FAIL bp_no_write_in_dump: writes %0d want 0", wr_log.size());
        end
        repeat (4) tick();
        n_tests++;
        if (wr_log.size() != 1) begin
            n_fail++;
            $display("FAIL bp_stop1_count: writes %0d want 1", wr_log.size());
        end else if (wr_log[0].addr !== 5'd4 || wr_log[0].data !== 32'd0 ||
                     wr_log[0].cyc != last + 2) begin
            n_fail++;
            $display("FAIL bp_stop1: addr %0d data %h cyc %0d want 4 0 %0d", wr_log[0].addr,
                     wr_log[0].data, wr_log[0].cyc, last + 2);
        end
    endtask

    task automatic test_dropped();
        int k;
        int n9;
        res_ready = 1'b1;
        wr_log.delete();
        tick();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        tick();
        tick();
        sec_start = 8'h04;
        tick();
        sec_start = '0;
        tick();
        sec_start = 8'h04;
        tick();
        sec_start = '0;
        n_tests++;
        if (dropped !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_set: dropped %b want 1", dropped);
        end
        k = 0;
        while (wr_log.size() == 0 && k < 80) begin
            tick();
            k++;
        end
        repeat (5) tick();
        n9 = 0;
        foreach (wr_log[i]) if (wr_log[i].addr === 5'd9) n9++;
        n_tests++;
        if (wr_log.size() != 1 || n9 != 1) begin
            n_fail++;
            $display("FAIL drop_single_write: writes %0d addr9 %0d want 1 1", wr_log.size(), n9);
        end
        n_tests++;
        if (dropped !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_sticky: dropped %b busy %b want 1 0", dropped, busy);
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n_tests++;
        if (dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_clear: dropped %b want 0", dropped);
        end
        tick();
        n_tests++;
        if (avm_write !== 1'b1 || avm_address !== 5'd0 || avm_writedata !== 32'h1) begin
            n_fail++;
            $display("FAIL clear_write: write %b addr %0d data %h want 1 0 00000001",
                     avm_write, avm_address, avm_writedata);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_dump();
        int bad;
        res_ready = 1'b1;
        wr_log.delete();
        tick();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        tick();
        n_tests++;
        if (avm_read !== 1'b1 || avm_address !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_rdlo: read %b addr %0d want 1 0", avm_read, avm_address);
        end
        tick();
        tick();
        n_tests++;
        if (avm_read !== 1'b1 || avm_address !== 5'd2) begin
            n_fail++;
            $display("FAIL rst_rdev: read %b addr %0d want 1 2", avm_read, avm_address);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if (avm_read !== 1'b0 || avm_begintransfer !== 1'b0 || avm_address !== 5'd0 ||
            res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: read %b bt %b addr %0d valid %b busy %b want all 0",
                     avm_read, avm_begintransfer, avm_address, res_valid, busy);
        end
        tick();
        tick();
        reset_n = 1'b1;
        bad = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0 || avm_read !== 1'b0 || avm_write !== 1'b0)
                bad++;
        end
        n_tests++;
        if (bad != 0 || wr_log.size() != 0) begin
            n_fail++;
            $display("FAIL rst_after: %0d active cycles, %0d writes want 0 0", bad, wr_log.size());
        end
    endtask

    initial begin
        for (int s = 0; s < 8; s++) begin
            mem[4*s]     = slave_word(s, 32'h11);
            mem[4*s + 1] = slave_word(s, 32'h22);
            mem[4*s + 2] = slave_word(s, 32'h33);
            mem[4*s + 3] = 32'hdead_beef;
        end
        reset_n   = 1'b1;
        sec_start = '0;
        sec_stop  = '0;
        clear_req = 1'b0;
        dump_req  = 1'b0;
        res_ready = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        test_reset();
        reset_n = 1'b1;
        test_start0();
        test_same_cycle();
        test_dump();
        test_backpressure();
        test_dropped();
        test_reset_mid_dump();
        n_tests++;
        if (proto_bad != 0) begin
            n_fail++;
            $display("FAIL bus_protocol: %0d bad strobe/data cycles want 0", proto_bad);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
